// File: rtl/mem_ctrl_if.sv
// Port bundle for mem_ctrl: fetch port, load/store port, flush/IO status and the byte-wide RAM bus.
// master = requesters plus RAM side; slave = mem_ctrl.
interface mem_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_en;
   logic [ADDR_W-1:0] if_pc;
   logic              if_done;
   logic [DATA_W-1:0] if_data;
   logic              lsb_en;
   logic              lsb_wr;
   logic [1:0]        lsb_len;
   logic [ADDR_W-1:0] lsb_addr;
   logic [DATA_W-1:0] lsb_w_data;
   logic              lsb_done;
   logic [DATA_W-1:0] lsb_r_data;
   logic              rob_clear;
   logic              io_buffer_full;
   logic [7:0]        mem_din;
   logic [7:0]        mem_dout;
   logic [ADDR_W-1:0] mem_a;
   logic              mem_wr;

   modport master (
      output if_en, if_pc, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data,
             rob_clear, io_buffer_full, mem_din,
      input  if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
   );

   modport slave (
      input  if_en, if_pc, lsb_en, lsb_wr, lsb_len, lsb_addr, lsb_w_data,
             rob_clear, io_buffer_full, mem_din,
      output if_done, if_data, lsb_done, lsb_r_data, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store requests onto a byte-wide, 1-cycle-latency RAM/IO bus (little-endian).
// Optional MC_IO_STALL_EN: IO-space stores stall while io_buffer_full is high.
module mem_ctrl #(
   parameter int         ADDR_W = 32,
   parameter int         DATA_W = 32,
   parameter logic [1:0] IO_SEL = 2'b11
) (
   input logic       clk,
   input logic       rst,
   input logic       rdy,
   mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, IF_RD, LS_RD, LS_WR, DONE} state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, n_q, len_n;
   logic [ADDR_W-1:0] a_q;
   logic [7:0]        dout_q;
   logic              wr_q;
   logic [DATA_W-1:0] rbuf_q, wdata_q, if_data_q, lsb_r_data_q;
   logic              if_done_q, lsb_done_q;
   logic              stall, last_wr;

   always_comb begin
      unique case (bus.lsb_len)
         2'd0:    len_n = 3'd1;
         2'd1:    len_n = 3'd2;
         default: len_n = 3'd4;
      endcase
   end

   assign last_wr = (3'(cnt_q + 3'd1) == n_q);

`ifdef MC_IO_STALL_EN
   assign stall = (state_q == LS_WR) && (a_q[17:16] == IO_SEL) && bus.io_buffer_full;
`else
   logic unused_io_full;
   assign unused_io_full = bus.io_buffer_full;
   assign stall = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)      state_q <= IDLE;
      else if (rdy) state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (bus.lsb_en && !bus.rob_clear) state_d = bus.lsb_wr ? LS_WR : LS_RD;
            else if (bus.if_en)               state_d = IF_RD;
         end
         IF_RD:   if (cnt_q == n_q) state_d = DONE;
         LS_RD: begin
            if (bus.rob_clear)      state_d = IDLE;
            else if (cnt_q == n_q)  state_d = DONE;
         end
         LS_WR:   if (!stall && last_wr) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath follows the chosen transition so the decode lives only in the next-state process.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= '0;
         n_q          <= '0;
         a_q          <= '0;
         dout_q       <= '0;
         wr_q         <= 1'b0;
         rbuf_q       <= '0;
         wdata_q      <= '0;
         if_data_q    <= '0;
         lsb_r_data_q <= '0;
         if_done_q    <= 1'b0;
         lsb_done_q   <= 1'b0;
      end else if (rdy) begin
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (state_d == LS_RD || state_d == LS_WR) begin
                  a_q     <= bus.lsb_addr;
                  n_q     <= len_n;
                  cnt_q   <= '0;
                  rbuf_q  <= '0;
                  dout_q  <= bus.lsb_w_data[7:0];
                  wdata_q <= bus.lsb_w_data >> 8;
                  wr_q    <= (state_d == LS_WR);
               end else if (state_d == IF_RD) begin
                  a_q    <= bus.if_pc;
                  n_q    <= 3'd4;
                  cnt_q  <= '0;
                  rbuf_q <= '0;
               end
            end
            IF_RD, LS_RD: begin
               if (state_d == DONE) begin
                  if (state_q == IF_RD) begin
                     if_done_q <= 1'b1;
                     if_data_q <= rbuf_q;
                  end else begin
                     lsb_done_q   <= 1'b1;
                     lsb_r_data_q <= rbuf_q;
                  end
               end else if (state_d == state_q) begin
                  rbuf_q[{cnt_q[1:0], 3'b000} +: 8] <= bus.mem_din;
                  cnt_q <= cnt_q + 3'd1;
                  a_q   <= a_q + ADDR_W'(1);
               end
            end
            LS_WR: begin
               if (state_d == DONE) begin
                  wr_q       <= 1'b0;
                  lsb_done_q <= 1'b1;
               end else if (!stall) begin
                  cnt_q   <= cnt_q + 3'd1;
                  a_q     <= a_q + ADDR_W'(1);
                  dout_q  <= wdata_q[7:0];
                  wdata_q <= wdata_q >> 8;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.mem_wr = wr_q && rdy && !stall;
   end

   assign bus.mem_a      = a_q;
   assign bus.mem_dout   = dout_q;
   assign bus.if_done    = if_done_q;
   assign bus.if_data    = if_data_q;
   assign bus.lsb_done   = lsb_done_q;
   assign bus.lsb_r_data = lsb_r_data_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: random fetch/load/store traffic against a byte-array RAM model.
module tb_mem_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rdy = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   logic [7:0]  ram [logic [31:0]];
   logic [39:0] wlog [$];

   mem_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_ctrl #(.ADDR_W(32), .DATA_W(32), .IO_SEL(2'b11)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] rd(input logic [31:0] a);
      if (ram.exists(a)) return ram[a];
      return 8'h00;
   endfunction

   // RAM/IO side: writes land when mem_wr is seen; read data for the current address is ready by the next edge.
   always @(negedge clk) begin
      if (bus.mem_wr === 1'b1) begin
         ram[bus.mem_a] = bus.mem_dout;
         wlog.push_back({bus.mem_a, bus.mem_dout});
      end
      bus.mem_din = rd(bus.mem_a);
   end

   function automatic int nb(input logic [1:0] len);
      return (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a, input int n);
      logic [31:0] v = '0;
      for (int i = 0; i < n; i++) v = v | (32'(rd(a + 32'(i))) << (8 * i));
      return v;
   endfunction

   task automatic put4(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++) ram[a + 32'(i)] = w[8*i +: 8];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_if(input logic [31:0] pc, input bit rob, output int lat,
                         output logic [31:0] d, output logic still);
      int t0;
      bus.if_en = 1'b1;
      bus.if_pc = pc;
      t0  = cyc + 1;
      lat = -1;
      d   = '0;
      for (int k = 0; k < 60 && lat < 0; k++) begin
         step();
         if (bus.if_done === 1'b1) begin
            lat = cyc - t0;
            d   = bus.if_data;
            bus.if_en = 1'b0;
         end else if (rob && cyc == t0) bus.rob_clear = 1'b1;
      end
      bus.if_en = 1'b0;
      bus.rob_clear = 1'b0;
      step();
      still = bus.if_done;
   endtask

   task automatic run_lsb(input logic wr, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] wd, input int gap, input int stall, input bit rob,
                          output int lat, output logic [31:0] d, output logic still);
      int t0;
      bus.lsb_en = 1'b1;
      bus.lsb_wr = wr;
      bus.lsb_len = len;
      bus.lsb_addr = a;
      bus.lsb_w_data = wd;
      bus.io_buffer_full = (stall > 0);
      t0  = cyc + 1;
      lat = -1;
      d   = '0;
      for (int k = 0; k < 80 && lat < 0; k++) begin
         step();
         if (bus.lsb_done === 1'b1) begin
            lat = cyc - t0;
            d   = bus.lsb_r_data;
            bus.lsb_en = 1'b0;
         end else begin
            if (rob && cyc == t0) bus.rob_clear = 1'b1;
            if (gap > 0 && cyc == t0 + 1) rdy = 1'b0;
            if (cyc == t0 + 1 + gap) rdy = 1'b1;
            if (cyc == t0 + stall) bus.io_buffer_full = 1'b0;
         end
      end
      bus.lsb_en = 1'b0;
      bus.rob_clear = 1'b0;
      bus.io_buffer_full = 1'b0;
      rdy = 1'b1;
      step();
      still = bus.lsb_done;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      total += 7;
      if (bus.if_done !== 1'b0)  begin bad++; $display("FAIL reset_if_done got=%b want=0", bus.if_done); end
      if (bus.lsb_done !== 1'b0) begin bad++; $display("FAIL reset_lsb_done got=%b want=0", bus.lsb_done); end
      if (bus.mem_wr !== 1'b0)   begin bad++; $display("FAIL reset_mem_wr got=%b want=0", bus.mem_wr); end
      if (bus.mem_a !== 32'h0)   begin bad++; $display("FAIL reset_mem_a got=%h want=0", bus.mem_a); end
      if (bus.mem_dout !== 8'h0) begin bad++; $display("FAIL reset_mem_dout got=%h want=0", bus.mem_dout); end
      if (bus.if_data !== 32'h0) begin bad++; $display("FAIL reset_if_data got=%h want=0", bus.if_data); end
      if (bus.lsb_r_data !== 32'h0) begin bad++; $display("FAIL reset_lsb_r_data got=%h want=0", bus.lsb_r_data); end
   endtask

   task automatic test_fetch();
      int lat; logic [31:0] d, pc, w; logic still;
      ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05; ram[32'h1002] = 8'h00; ram[32'h1003] = 8'h00;
      wlog.delete();
      run_if(32'h1000, 1'b0, lat, d, still);
      total += 4;
      if (lat !== 5) begin bad++; $display("FAIL fetch_latency got=%0d want=5", lat); end
      if (d !== 32'h00000513) begin bad++; $display("FAIL fetch_data got=%h want=00000513", d); end
      if (still !== 1'b0) begin bad++; $display("FAIL fetch_pulse_width got=%b want=0", still); end
      if (wlog.size() != 0) begin bad++; $display("FAIL fetch_no_write got=%0d want=0", wlog.size()); end
      repeat (3) step();
      total++;
      if (bus.if_data !== 32'h00000513) begin bad++; $display("FAIL fetch_data_hold got=%h want=00000513", bus.if_data); end
      for (int t = 0; t < 6; t++) begin
         pc = $urandom & 32'hFFFF_FFFC;
         w  = $urandom;
         put4(pc, w);
         run_if(pc, 1'b0, lat, d, still);
         total += 2;
         if (lat !== 5) begin bad++; $display("FAIL fetch_rand_latency pc=%h got=%0d want=5", pc, lat); end
         if (d !== w) begin bad++; $display("FAIL fetch_rand_data pc=%h got=%h want=%h", pc, d, w); end
      end
   endtask

   task automatic test_load();
      int lat, gap, n; logic [31:0] d, a, e; logic [1:0] len; logic still;
      for (int t = 0; t < 10; t++) begin
         a   = $urandom;
         len = 2'($urandom_range(0, 2));
         gap = (t % 2 == 1) ? int'($urandom_range(1, 3)) : 0;
         n   = nb(len);
         put4(a, $urandom);
         e = exp_word(a, n);
         wlog.delete();
         run_lsb(1'b0, len, a, 32'h0, gap, 0, 1'b0, lat, d, still);
         total += 4;
         if (lat !== n + 1 + gap) begin bad++; $display("FAIL load_latency a=%h len=%0d gap=%0d got=%0d want=%0d", a, len, gap, lat, n + 1 + gap); end
         if (d !== e) begin bad++; $display("FAIL load_data a=%h len=%0d got=%h want=%h", a, len, d, e); end
         if (still !== 1'b0) begin bad++; $display("FAIL load_pulse_width got=%b want=0", still); end
         if (wlog.size() != 0) begin bad++; $display("FAIL load_no_write got=%0d want=0", wlog.size()); end
      end
   endtask

   task automatic test_store();
      int lat, gap, n, el; logic [31:0] d, a, wd, ea; logic [1:0] len; logic still;
      for (int t = 0; t < 12; t++) begin
         if (t == 0) begin a = 32'h2001; len = 2'd1; wd = 32'h0000BEEF; gap = 0; end
         else if (t == 1) begin a = 32'hFFFF_FFFE; len = 2'd2; wd = 32'hA1B2C3D4; gap = 0; end
         else begin
            a   = $urandom;
            len = 2'($urandom_range(0, 2));
            wd  = $urandom;
            gap = (t % 3 == 0) ? int'($urandom_range(1, 3)) : 0;
         end
         n  = nb(len);
         el = n + ((n >= 2) ? gap : 0);
         wlog.delete();
         run_lsb(1'b1, len, a, wd, gap, 0, 1'b0, lat, d, still);
         total += 3;
         if (lat !== el) begin bad++; $display("FAIL store_latency a=%h len=%0d gap=%0d got=%0d want=%0d", a, len, gap, lat, el); end
         if (still !== 1'b0) begin bad++; $display("FAIL store_pulse_width got=%b want=0", still); end
         if (wlog.size() != n) begin bad++; $display("FAIL store_write_count a=%h got=%0d want=%0d", a, wlog.size(), n); end
         for (int i = 0; i < n && i < wlog.size(); i++) begin
            ea = a + 32'(i);
            total++;
            if (wlog[i] !== {ea, wd[8*i +: 8]})
               begin bad++; $display("FAIL store_byte i=%0d got=%h want=%h", i, wlog[i], {ea, wd[8*i +: 8]}); end
         end
      end
   endtask

   task automatic test_back_to_back();
      int t0, ld, id; logic [31:0] ldat, idat;
      put4(32'h2000, 32'h12345678);
      put4(32'h1000, 32'h00000513);
      ldat = '0; idat = '0;
      bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd2; bus.lsb_addr = 32'h2000;
      bus.if_en = 1'b1; bus.if_pc = 32'h1000;
      t0 = cyc + 1; ld = -1; id = -1;
      for (int k = 0; k < 60 && id < 0; k++) begin
         step();
         if (bus.lsb_done === 1'b1 && ld < 0) begin ld = cyc - t0; ldat = bus.lsb_r_data; bus.lsb_en = 1'b0; end
         if (bus.if_done === 1'b1) begin id = cyc - t0; idat = bus.if_data; bus.if_en = 1'b0; end
      end
      bus.lsb_en = 1'b0; bus.if_en = 1'b0;
      step();
      total += 4;
      if (ld !== 5) begin bad++; $display("FAIL arb_lsb_latency got=%0d want=5", ld); end
      if (ldat !== 32'h12345678) begin bad++; $display("FAIL arb_lsb_data got=%h want=12345678", ldat); end
      if (id !== 12) begin bad++; $display("FAIL arb_fetch_after_done got=%0d want=12", id); end
      if (idat !== 32'h00000513) begin bad++; $display("FAIL arb_fetch_data got=%h want=00000513", idat); end
   endtask

   task automatic test_rob_clear();
      int t0, ls, id, lat; logic [31:0] idat, d, a, e; logic still;
      put4(32'h1000, 32'h00000513);
      put4(32'h3000, $urandom);
      idat = '0;
      bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd2; bus.lsb_addr = 32'h3000;
      bus.if_en = 1'b1; bus.if_pc = 32'h1000;
      t0 = cyc + 1; ls = 0; id = -1;
      for (int k = 0; k < 60 && id < 0; k++) begin
         step();
         if (bus.lsb_done === 1'b1) ls++;
         if (bus.if_done === 1'b1) begin id = cyc - t0; idat = bus.if_data; bus.if_en = 1'b0; end
         if (cyc == t0 + 3) begin bus.rob_clear = 1'b1; bus.lsb_en = 1'b0; end
         if (cyc == t0 + 4) bus.rob_clear = 1'b0;
      end
      bus.if_en = 1'b0; bus.rob_clear = 1'b0;
      step();
      total += 3;
      if (ls !== 0) begin bad++; $display("FAIL rob_abort_no_done got=%0d want=0", ls); end
      if (id !== 10) begin bad++; $display("FAIL rob_then_fetch_latency got=%0d want=10", id); end
      if (idat !== 32'h00000513) begin bad++; $display("FAIL rob_then_fetch_data got=%h want=00000513", idat); end

      run_if(32'h1000, 1'b1, lat, d, still);
      total += 2;
      if (lat !== 5) begin bad++; $display("FAIL rob_fetch_not_aborted got=%0d want=5", lat); end
      if (d !== 32'h00000513) begin bad++; $display("FAIL rob_fetch_data got=%h want=00000513", d); end

      wlog.delete();
      run_lsb(1'b1, 2'd2, 32'h5000, 32'hCAFEF00D, 0, 0, 1'b1, lat, d, still);
      total += 2;
      if (lat !== 4) begin bad++; $display("FAIL rob_store_completes got=%0d want=4", lat); end
      if (wlog.size() != 4) begin bad++; $display("FAIL rob_store_writes got=%0d want=4", wlog.size()); end

      a = 32'h6000 + ($urandom & 32'hFF);
      ram[a] = 8'($urandom);
      e = exp_word(a, 1);
      bus.lsb_en = 1'b1; bus.lsb_wr = 1'b0; bus.lsb_len = 2'd0; bus.lsb_addr = a;
      bus.rob_clear = 1'b1;
      t0 = cyc + 1; lat = -1; d = '0;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         step();
         if (bus.lsb_done === 1'b1) begin lat = cyc - t0; d = bus.lsb_r_data; bus.lsb_en = 1'b0; end
         else if (cyc == t0 + 1) bus.rob_clear = 1'b0;
      end
      bus.lsb_en = 1'b0; bus.rob_clear = 1'b0;
      step();
      total += 2;
      if (lat !== 4) begin bad++; $display("FAIL rob_idle_blocks_lsb got=%0d want=4", lat); end
      if (d !== e) begin bad++; $display("FAIL rob_idle_load_data got=%h want=%h", d, e); end
   endtask

   task automatic test_io_stall();
      int lat, el; logic [31:0] d; logic still;
`ifdef MC_IO_STALL_EN
      el = 4;
`else
      el = 1;
`endif
      wlog.delete();
      run_lsb(1'b1, 2'd0, 32'h0003_0000, 32'h0000_005A, 0, 3, 1'b0, lat, d, still);
      total += 3;
      if (lat !== el) begin bad++; $display("FAIL io_stall_latency got=%0d want=%0d", lat, el); end
      if (wlog.size() != 1) begin bad++; $display("FAIL io_stall_write_count got=%0d want=1", wlog.size()); end
      if (rd(32'h0003_0000) !== 8'h5A) begin bad++; $display("FAIL io_stall_byte got=%h want=5a", rd(32'h0003_0000)); end
      wlog.delete();
      run_lsb(1'b1, 2'd0, 32'h0002_0000, 32'h0000_00A5, 0, 3, 1'b0, lat, d, still);
      total += 2;
      if (lat !== 1) begin bad++; $display("FAIL non_io_no_stall got=%0d want=1", lat); end
      if (wlog.size() != 1) begin bad++; $display("FAIL non_io_write_count got=%0d want=1", wlog.size()); end
   endtask

   task automatic test_reset_mid();
      int seen, lat; logic [31:0] d, wd; logic still;
      put4(32'h1000, 32'h00000513);
      bus.if_en = 1'b1; bus.if_pc = 32'h1000;
      step(); step();
      rst = 1'b1; bus.if_en = 1'b0;
      step();
      rst = 1'b0;
      total += 5;
      if (bus.if_done !== 1'b0)  begin bad++; $display("FAIL rst_mid_if_done got=%b want=0", bus.if_done); end
      if (bus.if_data !== 32'h0) begin bad++; $display("FAIL rst_mid_if_data got=%h want=0", bus.if_data); end
      if (bus.mem_a !== 32'h0)   begin bad++; $display("FAIL rst_mid_mem_a got=%h want=0", bus.mem_a); end
      if (bus.mem_wr !== 1'b0)   begin bad++; $display("FAIL rst_mid_mem_wr got=%b want=0", bus.mem_wr); end
      if (bus.lsb_r_data !== 32'h0) begin bad++; $display("FAIL rst_mid_lsb_r_data got=%h want=0", bus.lsb_r_data); end
      seen = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (bus.if_done === 1'b1) seen++;
      end
      total++;
      if (seen !== 0) begin bad++; $display("FAIL rst_mid_no_done got=%0d want=0", seen); end
      run_if(32'h1000, 1'b0, lat, d, still);
      total += 2;
      if (lat !== 5) begin bad++; $display("FAIL rst_refetch_latency got=%0d want=5", lat); end
      if (d !== 32'h00000513) begin bad++; $display("FAIL rst_refetch_data got=%h want=00000513", d); end

      wd = $urandom;
      wlog.delete();
      bus.lsb_en = 1'b1; bus.lsb_wr = 1'b1; bus.lsb_len = 2'd2; bus.lsb_addr = 32'h4000; bus.lsb_w_data = wd;
      step(); step();
      rst = 1'b1; bus.lsb_en = 1'b0;
      step();
      rst = 1'b0;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (bus.lsb_done === 1'b1) seen++;
      end
      total += 3;
      if (wlog.size() != 2) begin bad++; $display("FAIL rst_store_write_count got=%0d want=2", wlog.size()); end
      if (seen !== 0) begin bad++; $display("FAIL rst_store_no_done got=%0d want=0", seen); end
      if (wlog.size() >= 2 && wlog[1] !== {32'h4001, wd[15:8]})
         begin bad++; $display("FAIL rst_store_byte1 got=%h want=%h", wlog[1], {32'h4001, wd[15:8]}); end
   endtask

   initial begin
      bus.if_en = 1'b0; bus.if_pc = '0;
      bus.lsb_en = 1'b0; bus.lsb_wr = 1'b0; bus.lsb_len = '0; bus.lsb_addr = '0; bus.lsb_w_data = '0;
      bus.rob_clear = 1'b0; bus.io_buffer_full = 1'b0;
      test_reset();
      test_fetch();
      test_load();
      test_store();
      test_back_to_back();
      test_rob_clear();
      test_io_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end
endmodule
